// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and pointer wrap function for fifo_sync_flags
package fifo_pkg;

    // Pointer width; a depth of 2 still needs one bit.
    function automatic int ptr_w(input int d);
        return (d > 2) ? $clog2(d) : 1;
    endfunction

    // Occupancy width; must represent 0..d inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    // Next pointer value with wrap at d-1, so depth need not be a power of two.
    function automatic int wrap_inc(input int p, input int d);
        return (p == d - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// rtl/fifo_sync_flags_if.sv - producer/consumer bundle for fifo_sync_flags (optional FIFO_ERR_FLAGS_EN signals)
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int bits  = 8,
    parameter int depth = 4
);
    localparam int CW = cnt_w(depth);

    logic            push;
    logic [bits-1:0] Din;
    logic            pop;
    logic [bits-1:0] Dout;
    logic            full;
    logic            pndng;
    logic            almost_full;
    logic            almost_empty;
    logic [CW-1:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic            err_clr;
    logic            overflow;
    logic            underflow;
`endif

`ifdef FIFO_ERR_FLAGS_EN
    modport master (
        output push, Din, pop, err_clr,
        input  Dout, full, pndng, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  push, Din, pop, err_clr,
        output Dout, full, pndng, almost_full, almost_empty, count, overflow, underflow
    );
`else
    modport master (
        output push, Din, pop,
        input  Dout, full, pndng, almost_full, almost_empty, count
    );
    modport slave (
        input  push, Din, pop,
        output Dout, full, pndng, almost_full, almost_empty, count
    );
`endif

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, occupancy count, accept decisions and flags (FIFO_ERR_FLAGS_EN adds sticky errors)
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int depth    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    localparam int PW      = ptr_w(depth),
    localparam int CW      = cnt_w(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow,
`endif
    output logic          push_ok,
    output logic          pop_ok,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          pndng,
    output logic          almost_full,
    output logic          almost_empty
);

    // All flags are pure decodes of the registered count.
    assign full         = (count == CW'(depth));
    assign pndng        = (count != '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
    // A pop on an empty FIFO is never legal, even alongside a push (the word is not visible yet).
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & pndng;

    // Pointer and occupancy update; simultaneous accept leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= PW'(wrap_inc(int'(wr_ptr), depth));
            end
            if (pop_ok) begin
                rd_ptr <= PW'(wrap_inc(int'(rd_ptr), depth));
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error capture; err_clr takes priority over an error raised in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FWFT FIFO with count and almost flags (FIFO_ERR_FLAGS_EN adds error flags)
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int bits     = 8,
    parameter int depth    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_sync_flags_if.slave bus
);

    localparam int PW = ptr_w(depth);

    logic [bits-1:0] mem [depth];
    logic            push_ok;
    logic            pop_ok;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    fifo_ptr_ctrl #(
        .depth    (depth),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .push         (bus.push),
        .pop          (bus.pop),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (bus.err_clr),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow),
`endif
        .push_ok      (push_ok),
        .pop_ok       (pop_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (bus.count),
        .full         (bus.full),
        .pndng        (bus.pndng),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty)
    );

    // Storage write; contents are deliberately not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.Din;
        end
    end

    // Head word is visible without a pop (FWFT); forced to zero while empty.
    assign bus.Dout = bus.pndng ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - directed self-checking bench for fifo_sync_flags
module tb_fifo_sync_flags;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.bits(8), .depth(4)) fa ();
    fifo_sync_flags_if #(.bits(8), .depth(5)) fb ();

    fifo_sync_flags #(.bits(8), .depth(4), .AF_LEVEL(3), .AE_LEVEL(1)) ua (
        .clk (clk),
        .rst (rst),
        .bus (fa.slave)
    );

    fifo_sync_flags #(.bits(8), .depth(5), .AF_LEVEL(3), .AE_LEVEL(1)) ub (
        .clk (clk),
        .rst (rst),
        .bus (fb.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        checks++; if (fa.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fa.count); end
        checks++; if (fa.pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng got=%b exp=0", fa.pndng); end
        checks++; if (fa.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fa.full); end
        checks++; if (fa.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", fa.almost_empty); end
        checks++; if (fa.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", fa.almost_full); end
        checks++; if (fa.Dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", fa.Dout); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++; if (fa.overflow !== 1'b0 || fa.underflow !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b%b exp=00", fa.overflow, fa.underflow);
        end
`endif
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [2:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            fa.push = 1'b1; fa.Din = vals[i];
            cyc();
            exp_cnt = 3'(i + 1);
            checks++; if (fa.count !== exp_cnt) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", fa.count, exp_cnt); end
            checks++; if (fa.almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, fa.almost_full, (i >= 2)); end
            checks++; if (fa.full !== (i == 3)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, fa.full, (i == 3)); end
            checks++; if (fa.almost_empty !== (i == 0)) begin errors++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, fa.almost_empty, (i == 0)); end
            checks++; if (fa.Dout !== 8'h11) begin errors++; $display("FAIL fill_dout got=%h exp=11", fa.Dout); end
        end
        fa.Din = 8'h55;
        cyc();
        fa.push = 1'b0;
        checks++; if (fa.count !== 3'd4) begin errors++; $display("FAIL overfill_count got=%0d exp=4", fa.count); end
        checks++; if (fa.Dout !== 8'h11) begin errors++; $display("FAIL overfill_dout got=%h exp=11", fa.Dout); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++; if (fa.overflow !== 1'b1) begin errors++; $display("FAIL overflow got=%b exp=1", fa.overflow); end
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (fa.Dout !== vals[i]) begin errors++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, fa.Dout, vals[i]); end
            fa.pop = 1'b1;
            cyc();
            fa.pop = 1'b0;
        end
        checks++; if (fa.count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", fa.count); end
        checks++; if (fa.pndng !== 1'b0 || fa.Dout !== 8'h00) begin
            errors++; $display("FAIL drain_empty got pndng=%b dout=%h exp pndng=0 dout=00", fa.pndng, fa.Dout);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] outs [4] = '{8'h22, 8'h33, 8'h44, 8'hAA};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fa.push = 1'b1; fa.Din = vals[i];
            cyc();
        end
        checks++; if (fa.Dout !== 8'h11 || fa.full !== 1'b1) begin
            errors++; $display("FAIL fpp_pre got dout=%h full=%b exp dout=11 full=1", fa.Dout, fa.full);
        end
        fa.Din = 8'hAA; fa.pop = 1'b1;
        cyc();
        fa.push = 1'b0; fa.pop = 1'b0;
        checks++; if (fa.count !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d exp=4", fa.count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (fa.Dout !== outs[i]) begin errors++; $display("FAIL fpp_drain i=%0d got=%h exp=%h", i, fa.Dout, outs[i]); end
            fa.pop = 1'b1;
            cyc();
            fa.pop = 1'b0;
        end
        checks++; if (fa.count !== 3'd0) begin errors++; $display("FAIL fpp_end_count got=%0d exp=0", fa.count); end
    endtask

    task automatic test_empty_push_pop();
        fa.push = 1'b1; fa.pop = 1'b1; fa.Din = 8'h5A;
        cyc();
        fa.push = 1'b0; fa.pop = 1'b0;
        checks++; if (fa.count !== 3'd1) begin errors++; $display("FAIL epp_count got=%0d exp=1", fa.count); end
        checks++; if (fa.pndng !== 1'b1 || fa.Dout !== 8'h5A) begin
            errors++; $display("FAIL epp_dout got pndng=%b dout=%h exp pndng=1 dout=5a", fa.pndng, fa.Dout);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++; if (fa.underflow !== 1'b1) begin errors++; $display("FAIL underflow got=%b exp=1", fa.underflow); end
`endif
        fa.pop = 1'b1;
        cyc();
        fa.pop = 1'b0;
        checks++; if (fa.count !== 3'd0) begin errors++; $display("FAIL epp_end_count got=%0d exp=0", fa.count); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] exp_head;
        fb.push = 1'b1; fb.Din = 8'h01;
        cyc();
        fb.Din = 8'h02;
        cyc();
        for (int k = 0; k < 12; k++) begin
            exp_head = 8'(k + 1);
            checks++; if (fb.Dout !== exp_head) begin errors++; $display("FAIL wrap_dout k=%0d got=%h exp=%h", k, fb.Dout, exp_head); end
            fb.push = 1'b1; fb.pop = 1'b1; fb.Din = 8'(k + 3);
            cyc();
            checks++; if (fb.count !== 3'd2) begin errors++; $display("FAIL wrap_count k=%0d got=%0d exp=2", k, fb.count); end
        end
        fb.push = 1'b0;
        checks++; if (fb.Dout !== 8'h0D) begin errors++; $display("FAIL wrap_tail0 got=%h exp=0d", fb.Dout); end
        cyc();
        checks++; if (fb.Dout !== 8'h0E) begin errors++; $display("FAIL wrap_tail1 got=%h exp=0e", fb.Dout); end
        cyc();
        fb.pop = 1'b0;
        checks++; if (fb.count !== 3'd0 || fb.pndng !== 1'b0) begin
            errors++; $display("FAIL wrap_end got count=%0d pndng=%b exp 0 0", fb.count, fb.pndng);
        end
    endtask

    task automatic test_mid_reset();
        fa.push = 1'b1; fa.Din = 8'h77;
        cyc();
        fa.Din = 8'h88;
        cyc();
        fa.push = 1'b0;
        checks++; if (fa.count !== 3'd2) begin errors++; $display("FAIL mid_pre_count got=%0d exp=2", fa.count); end
        do_reset();
        checks++; if (fa.count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", fa.count); end
        checks++; if (fa.pndng !== 1'b0 || fa.Dout !== 8'h00) begin
            errors++; $display("FAIL mid_empty got pndng=%b dout=%h exp 0 00", fa.pndng, fa.Dout);
        end
    endtask

    task automatic test_err_clr();
`ifdef FIFO_ERR_FLAGS_EN
        fa.pop = 1'b1;
        cyc();
        checks++; if (fa.underflow !== 1'b1) begin errors++; $display("FAIL errclr_set got=%b exp=1", fa.underflow); end
        fa.err_clr = 1'b1;
        cyc();
        fa.err_clr = 1'b0; fa.pop = 1'b0;
        checks++; if (fa.underflow !== 1'b0) begin errors++; $display("FAIL errclr_wins got=%b exp=0", fa.underflow); end
        cyc();
        checks++; if (fa.underflow !== 1'b0 || fa.overflow !== 1'b0) begin
            errors++; $display("FAIL errclr_hold got=%b%b exp=00", fa.overflow, fa.underflow);
        end
`endif
    endtask

    initial begin
        fa.push = 1'b0; fa.pop = 1'b0; fa.Din = '0;
        fb.push = 1'b0; fb.pop = 1'b0; fb.Din = '0;
`ifdef FIFO_ERR_FLAGS_EN
        fa.err_clr = 1'b0;
        fb.err_clr = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_back_to_back_wrap();
        test_mid_reset();
        test_err_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
